up_down_counter_param: RTL and testbench

Parametrised synchronous up/down counter with parallel load, count enable, programmable modulus and three run modes: wrap, saturate and one-shot. It is the generalised successor to the fixed 4-bit binary up/down counter in the sequential-logic library. It is intended as the standard counter primitive for timers, dividers and cascaded counter chains.

---
 rtl/cntr_pkg.sv | 9 +
 rtl/up_down_counter_param.sv | 64 ++++++
 tb/tb_up_down_counter_param.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cntr_pkg.sv
// cntr_pkg: shared encodings for up_down_counter_param.
//   RM_*     : run_mode encodings (2'b11 is reserved and behaves as wrap)
//   state_t  : one-shot FSM state
package cntr_pkg;
   localparam logic [1:0] RM_WRAP    = 2'b00;
   localparam logic [1:0] RM_SAT     = 2'b01;
   localparam logic [1:0] RM_ONESHOT = 2'b10;
   typedef enum logic {ST_ARMED = 1'b0, ST_FINISHED = 1'b1} state_t;
endpackage

// File: rtl/up_down_counter_param.sv
// up_down_counter_param: modulo-N up/down counter with load, enable and wrap/saturate/one-shot modes.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   en       : count enable
//   load     : synchronous parallel load (clamped to MODULUS-1), re-arms one-shot
//   mode     : 0 = up, 1 = down
//   run_mode : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   in       : parallel load value
//   out      : registered count
//   tc       : combinational terminal count, usable as next-stage enable
//   done     : one-shot completion flag
module up_down_counter_param
   import cntr_pkg::*;
#(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic             mode,
   input  logic [1:0]       run_mode,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             done
);
   localparam logic [WIDTH:0]   MOD  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   TOP  = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] TOPW = TOP[WIDTH-1:0];
   localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
   state_t           state, next_state;
   logic [WIDTH-1:0] term, load_val, wrap_val, cnt_val, next_out;
   logic [WIDTH:0]   step;
   logic             at_term, over, hold_term, fire;
   always_comb begin
      term      = mode ? '0 : TOPW;
      at_term   = out == term;
      tc        = en & ~load & at_term;
      load_val  = {1'b0, in} >= MOD ? TOPW : in;
      // one extra bit exposes the borrow (down) or the reach of MODULUS (up)
      step      = mode ? {1'b0, out} - ONE : {1'b0, out} + ONE;
      over      = mode ? step[WIDTH] : step == MOD;
      wrap_val  = mode ? TOPW : '0;
      hold_term = run_mode == RM_SAT || run_mode == RM_ONESHOT;
      cnt_val   = over ? (hold_term ? out : wrap_val) : step[WIDTH-1:0];
      fire      = en & ~load & at_term & (run_mode == RM_ONESHOT);
      next_out  = load ? load_val : (state == ST_FINISHED || !en) ? out : cnt_val;
      next_state = load ? ST_ARMED :
                   state == ST_FINISHED ? (run_mode == RM_ONESHOT ? ST_FINISHED : ST_ARMED) :
                   fire ? ST_FINISHED : ST_ARMED;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out   <= '0;
         state <= ST_ARMED;
      end else begin
         out   <= next_out;
         state <= next_state;
      end
   end
   assign done = state == ST_FINISHED;
endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param: directed self-checking bench for up_down_counter_param.
module tb_up_down_counter_param;
   logic       clk = 1'b0;
   logic       reset, en, load, mode, c_en;
   logic [1:0] run_mode;
   logic [3:0] din;
   logic [3:0] out16, out10, c0, c1;
   logic       tc16, tc10, done16, done10, ctc0, ctc1, cdone0, cdone1;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   up_down_counter_param #(.WIDTH(4)) d16 (
      .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode), .run_mode(run_mode),
      .in(din), .out(out16), .tc(tc16), .done(done16));
   up_down_counter_param #(.WIDTH(4), .MODULUS(10)) d10 (
      .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode), .run_mode(run_mode),
      .in(din), .out(out10), .tc(tc10), .done(done10));
   up_down_counter_param #(.WIDTH(4)) s0 (
      .clk(clk), .reset(reset), .en(c_en), .load(1'b0), .mode(1'b0), .run_mode(2'b00),
      .in(4'd0), .out(c0), .tc(ctc0), .done(cdone0));
   up_down_counter_param #(.WIDTH(4)) s1 (
      .clk(clk), .reset(reset), .en(ctc0), .load(1'b0), .mode(1'b0), .run_mode(2'b00),
      .in(4'd0), .out(c1), .tc(ctc1), .done(cdone1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0; run_mode = 2'b00; din = 4'd0; c_en = 1'b0;
      #12;
      chk("rst_out", 32'(out16), 0);
      chk("rst_done", 32'(done16), 0);
      chk("rst_tc_en0", 32'(tc16), 0);
      en = 1'b1; mode = 1'b1;
      #1;
      chk("rst_tc_down", 32'(tc16), 1);
      en = 1'b0; mode = 1'b0;
      reset = 1'b1;
      tick();
      // reset in the middle of counting
      en = 1'b1;
      tick(); tick(); tick();
      chk("cnt3", 32'(out16), 3);
      #2 reset = 1'b0;
      #1;
      chk("async_rst", 32'(out16), 0);
      reset = 1'b1; en = 1'b0;
      // load, then load with en held high
      load = 1'b1; din = 4'd9;
      tick();
      chk("load9", 32'(out16), 9);
      din = 4'd15; en = 1'b1;
      #1;
      chk("tc_masked_by_load", 32'(tc16), 0);
      tick();
      chk("load15_no_inc", 32'(out16), 15);
      // wrap up then down
      din = 4'd14; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; mode = 1'b0;
      #1;
      chk("tc_at14", 32'(tc16), 0);
      tick();
      chk("up15", 32'(out16), 15);
      chk("tc_at15", 32'(tc16), 1);
      tick();
      chk("wrap_0", 32'(out16), 0);
      tick();
      chk("up_1", 32'(out16), 1);
      mode = 1'b1;
      #1;
      chk("tc_down_at1", 32'(tc16), 0);
      tick();
      chk("down_0", 32'(out16), 0);
      chk("tc_down_at0", 32'(tc16), 1);
      tick();
      chk("wrap_15", 32'(out16), 15);
      // modulus 10
      en = 1'b0; mode = 1'b0; run_mode = 2'b00;
      reset = 1'b0; #1 reset = 1'b1;
      en = 1'b1;
      #1;
      chk("m10_tc0", 32'(tc10), 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("m10_out", 32'(out10), (i == 10) ? 0 : i);
         chk("m10_tc", 32'(tc10), (i == 9) ? 1 : 0);
      end
      load = 1'b1; din = 4'd12;
      tick();
      chk("m10_clamp", 32'(out10), 9);
      chk("m16_noclamp", 32'(out16), 12);
      // saturate down
      run_mode = 2'b01; mode = 1'b1; din = 4'd2; en = 1'b0;
      tick();
      chk("sat_load2", 32'(out16), 2);
      load = 1'b0; en = 1'b1;
      tick(); chk("sat_1", 32'(out16), 1);
      tick(); chk("sat_0a", 32'(out16), 0);
      tick(); chk("sat_0b", 32'(out16), 0);
      tick(); chk("sat_0c", 32'(out16), 0);
      tick(); chk("sat_0d", 32'(out16), 0);
      chk("sat_done", 32'(done16), 0);
      mode = 1'b0;
      tick();
      chk("sat_up1", 32'(out16), 1);
      // one-shot up
      run_mode = 2'b10; mode = 1'b0; load = 1'b1; din = 4'd13; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      chk("os_14", 32'(out16), 14);
      tick();
      chk("os_15", 32'(out16), 15);
      chk("os_done_pre", 32'(done16), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("os_hold", 32'(out16), 15);
         chk("os_done", 32'(done16), 1);
      end
      load = 1'b1; din = 4'd3;
      tick();
      chk("os_reload", 32'(out16), 3);
      chk("os_done_clr", 32'(done16), 0);
      load = 1'b0;
      tick();
      chk("os_resume", 32'(out16), 4);
      // leaving one-shot mode re-arms, and a reset clears FINISHED
      din = 4'd15; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("os_fin2", 32'(done16), 1);
      run_mode = 2'b00;
      tick();
      chk("os_leave_done", 32'(done16), 0);
      chk("os_leave_hold", 32'(out16), 15);
      tick();
      chk("os_leave_wrap", 32'(out16), 0);
      // two-stage cascade
      en = 1'b0;
      reset = 1'b0; #1 reset = 1'b1;
      chk("casc_rst", 32'({c1, c0}), 0);
      c_en = 1'b1;
      repeat (300) tick();
      c_en = 1'b0;
      chk("casc_300", 32'({c1, c0}), 44);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
